periph_bridge: RTL and testbench
================================

Name: periph_bridge

Overview:
- Downstream of the core's peripheral data port; consumes `d_addr`, `d_wdata`, `d_store_type` and `d_valid`, and returns `d_rdata` and `d_ready`.
- Decodes the address into one of `NUM_SLAVES` fixed-size peripheral windows above `PERIPHERAL_BASE`, issues a single request to that slave and waits for its ready.
- Produces byte strobes for stores.
- Converts decode errors, misalignment and slave timeouts into a completed response plus an error flag, so the core stall can never hang.

Parameters:
- `PERIPHERAL_BASE`, 64'h2000_0000: base address of window 0.
- `NUM_SLAVES`, 4: number of peripheral windows/slaves.
- `SLOT_BITS`, 12: log2 window size in bytes (4 KiB per slave).
- `TIMEOUT`, 255: max cycles waiting for slave ready before error completion.

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `d_addr`  in  64  core data address
- `d_wdata`  in  64  core store data (right-aligned)
- `d_store_type`  in  3  0=load, 1=byte, 2=half, 3=word, 4=dword, 5-7 illegal
- `d_valid`  in  1  core request; held stable until `d_ready`
- `d_rdata`  out  64  aligned doubleword read data
- `d_ready`  out  1  one-cycle completion pulse
- `p_req`  out  NUM_SLAVES  one-hot slave request
- `p_addr`  out  SLOT_BITS  byte offset within window, low 3 bits forced 0
- `p_wdata`  out  64  store data shifted into byte lanes
- `p_we`  out  1  1=write, 0=read
- `p_wstrb`  out  8  byte-lane strobes (0 for reads)
- `p_rdata`  in  NUM_SLAVES*64  packed slave read data; slave i at [64i+63:64i]
- `p_ready`  in  NUM_SLAVES  per-slave completion
- `bus_error`  out  1  one-cycle pulse on any error completion
- `err_addr`  out  64  address of the most recent error; sticky until the next error

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to `IDLE`.
  - `d_ready`, `p_req`, `p_we`, `p_wstrb`, `bus_error` = 0.
  - `d_rdata`, `p_addr`, `p_wdata`, `err_addr` = 0.
  - Timeout counter = 0.
  - Reset mid-transaction abandons the transaction with no response.
- All outputs are registered.
- FSM states: `IDLE`, `REQ`, `RESP`.
- `IDLE`:
  - On `d_valid`, latch the request and decode it.
  - Slot index = `(d_addr - PERIPHERAL_BASE) >> SLOT_BITS`.
  - Decode error if `d_addr < PERIPHERAL_BASE`, slot index >= `NUM_SLAVES`, or `d_store_type` is 5-7.
  - Misaligned if the address is not naturally aligned for the store size (half: `addr[0]`; word: `addr[1:0]`; dword: `addr[2:0]`).
  - Any error: go to `RESP` with `d_rdata`=0, `bus_error`=1, `err_addr` = `d_addr`. No `p_req` is issued.
  - Otherwise go to `REQ` with `p_req[slot]`=1 and `p_addr` = `d_addr[SLOT_BITS-1:0] & ~7`.
  - Stores: `p_we`=1; `p_wstrb` = size mask (0x01 / 0x03 / 0x0F / 0xFF) shifted left by `d_addr[2:0]`; `p_wdata` = `d_wdata` shifted left by `8*d_addr[2:0]`.
- `REQ`:
  - `p_req` held until `p_ready[slot]`=1. Ready bits of unselected slaves are ignored.
  - On ready: capture `p_rdata` of the slot (0 for writes), drop `p_req`, go to `RESP`.
  - The counter increments each `REQ` cycle. When it reaches `TIMEOUT` without ready: drop `p_req`, `d_rdata`=0, `bus_error`=1, `err_addr` latched, go to `RESP`.
- `RESP`:
  - `d_ready`=1 for exactly one cycle; `bus_error` is high in this same cycle if this is an error completion.
  - Counter cleared, return to `IDLE`.
  - `d_valid` seen during `RESP` belongs to the completing request and is not re-accepted.
- Latency:
  - Request accepted at edge 0 (`IDLE`).
  - Earliest `d_ready` is 2 cycles after accept, when the slave is ready in its first `REQ` cycle.
  - Error completion: `d_ready` 1 cycle after accept.
- Back-to-back: a new `d_valid` in the first `IDLE` cycle after `RESP` is accepted immediately.
- `d_valid` deasserted while in `REQ` (protocol violation): the transaction still completes; the stray `d_ready` is harmless.
- Load data is the whole aligned doubleword; the core performs lane extraction and sign extension.

Test Plan:
- Load at `0x2000_1010`, slave 1 `p_ready` after 3 cycles with `p_rdata`=`0x1122334455667788` -> `p_req`=4'b0010, `p_addr`=0x010, `d_ready` pulses once with `d_rdata`=`0x1122334455667788`, `bus_error`=0.
- Byte store to `0x2000_0005`, `d_wdata`=0xAB -> `p_we`=1, `p_wstrb`=0x20, `p_wdata`=`0x0000_AB00_0000_0000`, `p_addr`=0x000, slave 0 selected.
- Word store to `0x2000_2002` (misaligned) -> no `p_req`, `d_ready` 1 cycle after accept, `bus_error` pulse, `err_addr`=`0x2000_2002`.
- Load at `0x2000_4000` (slot 4 with `NUM_SLAVES`=4) -> decode error; load at `0x1FFF_FFF8` -> decode error; both give `d_rdata`=0 and `bus_error`.
- Slave 2 never ready -> `p_req` deasserts after exactly 255 `REQ` cycles, `d_ready` and `bus_error` pulse together, the next request is accepted normally.
- `reset` asserted while in `REQ` -> all outputs 0 immediately (async), no `d_ready`; a subsequent request works. Also run two back-to-back requests with slaves ready in the first cycle -> `d_ready` pulses spaced 3 cycles apart.

Source files
------------

// File: rtl/periph_bridge_if.sv
// Bus bundle between the core data port, the bridge and the peripheral slaves.
//   master : core + slave environment (drives requests and slave responses)
//   slave  : the bridge itself (answers the core, drives the slave requests)
// Signals:
//   d_addr/d_wdata/d_store_type/d_valid -> core request
//   d_rdata/d_ready                     <- core response
//   p_req/p_addr/p_wdata/p_we/p_wstrb   -> slave request
//   p_rdata/p_ready                     <- slave response (slave i at [64i+63:64i])
//   bus_error/err_addr                  <- error reporting
interface periph_bridge_if #(
    parameter int NUM_SLAVES = 4,
    parameter int SLOT_BITS  = 12
);
    logic [63:0]              d_addr;
    logic [63:0]              d_wdata;
    logic [2:0]               d_store_type;
    logic                     d_valid;
    logic [63:0]              d_rdata;
    logic                     d_ready;
    logic [NUM_SLAVES-1:0]    p_req;
    logic [SLOT_BITS-1:0]     p_addr;
    logic [63:0]              p_wdata;
    logic                     p_we;
    logic [7:0]               p_wstrb;
    logic [NUM_SLAVES*64-1:0] p_rdata;
    logic [NUM_SLAVES-1:0]    p_ready;
    logic                     bus_error;
    logic [63:0]              err_addr;

    modport master (
        output d_addr, d_wdata, d_store_type, d_valid, p_rdata, p_ready,
        input  d_rdata, d_ready, p_req, p_addr, p_wdata, p_we, p_wstrb,
               bus_error, err_addr
    );

    modport slave (
        input  d_addr, d_wdata, d_store_type, d_valid, p_rdata, p_ready,
        output d_rdata, d_ready, p_req, p_addr, p_wdata, p_we, p_wstrb,
               bus_error, err_addr
    );
endinterface

// File: rtl/periph_bridge.sv
// Peripheral bridge: decodes a core data access into one of NUM_SLAVES
// fixed-size windows above PERIPHERAL_BASE, issues a single request to that
// slave and returns its data. Decode errors, misalignment and slave timeouts
// complete as an error response so the core can never stall forever.
// Ports:
//   clock - system clock
//   reset - asynchronous active-high reset
//   bus   - periph_bridge_if.slave (core request/response, slave bus, errors)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for d_valid; decodes and launches or errors out
// REQ   | p_req held to the selected slave, timeout counter running
// RESP  | d_ready (and bus_error if failed) high for this one cycle
module periph_bridge #(
    parameter logic [63:0] PERIPHERAL_BASE = 64'h2000_0000,
    parameter int          NUM_SLAVES      = 4,
    parameter int          SLOT_BITS       = 12,
    parameter int          TIMEOUT         = 255
) (
    input  logic           clock,
    input  logic           reset,
    periph_bridge_if.slave bus
);
    localparam int SLOT_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [63:0]           addr_q, addr_d;
    logic [63:0]           d_rdata_q, d_rdata_d;
    logic                  d_ready_q, d_ready_d;
    logic                  bus_error_q, bus_error_d;
    logic [63:0]           err_addr_q, err_addr_d;
    logic [NUM_SLAVES-1:0] p_req_q, p_req_d;
    logic [SLOT_BITS-1:0]  p_addr_q, p_addr_d;
    logic [63:0]           p_wdata_q, p_wdata_d;
    logic                  p_we_q, p_we_d;
    logic [7:0]            p_wstrb_q, p_wstrb_d;

    // Address decode of the incoming request
    logic [63:0]       offset;
    logic              below_base;
    logic              slot_oob;
    logic [SLOT_W-1:0] slot_idx;
    logic [7:0]        size_mask;
    logic              misalign;
    logic              bad_type;
    logic              is_store;
    logic              dec_err;
    logic [CNT_W-1:0]  cnt_next;
    logic [63:0]       slot_rdata;
    logic              slot_ready;

    assign offset     = bus.d_addr - PERIPHERAL_BASE;
    assign below_base = bus.d_addr < PERIPHERAL_BASE;
    // Full-width compare so far-away addresses cannot alias into a window
    assign slot_oob   = (offset >> SLOT_BITS) >= 64'(NUM_SLAVES);
    assign slot_idx   = offset[SLOT_BITS +: SLOT_W];
    assign is_store   = size_mask != 8'h00;
    assign dec_err    = below_base | slot_oob | bad_type | misalign;
    assign cnt_next   = cnt_q + CNT_W'(1);

    always_comb begin
        size_mask = 8'h00;
        misalign  = 1'b0;
        bad_type  = 1'b0;
        case (bus.d_store_type)
            3'd0: ;
            3'd1: size_mask = 8'h01;
            3'd2: begin
                size_mask = 8'h03;
                misalign  = bus.d_addr[0];
            end
            3'd3: begin
                size_mask = 8'h0F;
                misalign  = |bus.d_addr[1:0];
            end
            3'd4: begin
                size_mask = 8'hFF;
                misalign  = |bus.d_addr[2:0];
            end
            default: bad_type = 1'b1;
        endcase
    end

    // Only the selected slave's data and ready are ever looked at
    always_comb begin
        slot_rdata = '0;
        slot_ready = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (slot_q == SLOT_W'(i)) begin
                slot_rdata = bus.p_rdata[64*i +: 64];
                slot_ready = bus.p_ready[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        slot_d      = slot_q;
        addr_d      = addr_q;
        d_rdata_d   = d_rdata_q;
        d_ready_d   = 1'b0;
        bus_error_d = 1'b0;
        err_addr_d  = err_addr_q;
        p_req_d     = p_req_q;
        p_addr_d    = p_addr_q;
        p_wdata_d   = p_wdata_q;
        p_we_d      = p_we_q;
        p_wstrb_d   = p_wstrb_q;
        case (state_q)
            IDLE: begin
                if (bus.d_valid) begin
                    addr_d = bus.d_addr;
                    cnt_d  = '0;
                    if (dec_err) begin
                        state_d     = RESP;
                        d_ready_d   = 1'b1;
                        bus_error_d = 1'b1;
                        d_rdata_d   = '0;
                        err_addr_d  = bus.d_addr;
                    end else begin
                        state_d   = REQ;
                        slot_d    = slot_idx;
                        p_req_d   = NUM_SLAVES'(1) << slot_idx;
                        p_addr_d  = {bus.d_addr[SLOT_BITS-1:3], 3'b000};
                        p_we_d    = is_store;
                        p_wstrb_d = size_mask << bus.d_addr[2:0];
                        p_wdata_d = is_store ? (bus.d_wdata << {bus.d_addr[2:0], 3'b000}) : '0;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_next;
                if (slot_ready) begin
                    state_d   = RESP;
                    d_ready_d = 1'b1;
                    d_rdata_d = p_we_q ? '0 : slot_rdata;
                    p_req_d   = '0;
                    p_we_d    = 1'b0;
                    p_wstrb_d = '0;
                end else if (cnt_next == CNT_W'(TIMEOUT)) begin
                    state_d     = RESP;
                    d_ready_d   = 1'b1;
                    bus_error_d = 1'b1;
                    d_rdata_d   = '0;
                    err_addr_d  = addr_q;
                    p_req_d     = '0;
                    p_we_d      = 1'b0;
                    p_wstrb_d   = '0;
                end
            end
            RESP: begin
                // d_valid still belongs to the finishing request here
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            slot_q      <= '0;
            addr_q      <= '0;
            d_rdata_q   <= '0;
            d_ready_q   <= 1'b0;
            bus_error_q <= 1'b0;
            err_addr_q  <= '0;
            p_req_q     <= '0;
            p_addr_q    <= '0;
            p_wdata_q   <= '0;
            p_we_q      <= 1'b0;
            p_wstrb_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            addr_q      <= addr_d;
            d_rdata_q   <= d_rdata_d;
            d_ready_q   <= d_ready_d;
            bus_error_q <= bus_error_d;
            err_addr_q  <= err_addr_d;
            p_req_q     <= p_req_d;
            p_addr_q    <= p_addr_d;
            p_wdata_q   <= p_wdata_d;
            p_we_q      <= p_we_d;
            p_wstrb_q   <= p_wstrb_d;
        end
    end

    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.bus_error = bus_error_q;
    assign bus.err_addr  = err_addr_q;
    assign bus.p_req     = p_req_q;
    assign bus.p_addr    = p_addr_q;
    assign bus.p_wdata   = p_wdata_q;
    assign bus.p_we      = p_we_q;
    assign bus.p_wstrb   = p_wstrb_q;
endmodule

// File: tb/tb_periph_bridge.sv
// Testbench for periph_bridge: directed vector table, hand-written corner
// sequences (back-to-back, reset in REQ) and randomized requests checked
// against an arithmetic reference model of the address map and timing.
module tb_periph_bridge;
    localparam logic [63:0] BASE = 64'h2000_0000;

    typedef struct {
        logic [63:0] rdata;
        logic [63:0] wdata;
        logic [11:0] paddr;
        logic [7:0]  strb;
        logic [3:0]  req;
        logic        we;
        logic        berr;
        int          lat;
        int          reqcyc;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [2:0]  st;
        int          slat;
        logic [63:0] sdata;
        exp_t        e;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic [63:0] wdata;
        logic [63:0] err_addr;
        logic [11:0] paddr;
        logic [7:0]  strb;
        logic [3:0]  req;
        logic        we;
        logic        berr;
        logic        ready_after;
        int          lat;
        int          reqcyc;
        int          req_bad;
        int          stray;
        int          done_cyc;
    } res_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic [63:0] last_err = '0;

    periph_bridge_if #(.NUM_SLAVES(4), .SLOT_BITS(12)) bus ();

    periph_bridge #(
        .PERIPHERAL_BASE(BASE),
        .NUM_SLAVES(4),
        .SLOT_BITS(12),
        .TIMEOUT(255)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".d_ready"},   64'(bus.d_ready),   64'd0);
        check({tag, ".p_req"},     64'(bus.p_req),     64'd0);
        check({tag, ".p_we"},      64'(bus.p_we),      64'd0);
        check({tag, ".p_wstrb"},   64'(bus.p_wstrb),   64'd0);
        check({tag, ".bus_error"}, 64'(bus.bus_error), 64'd0);
        check({tag, ".d_rdata"},   bus.d_rdata,        64'd0);
        check({tag, ".p_addr"},    64'(bus.p_addr),    64'd0);
        check({tag, ".p_wdata"},   bus.p_wdata,        64'd0);
        check({tag, ".err_addr"},  bus.err_addr,       64'd0);
    endtask

    // Reference model: address map and timing from plain arithmetic
    function automatic exp_t model(input logic [63:0] addr, input logic [63:0] wdata,
                                   input logic [2:0] st, input int slat, input logic [63:0] sdata);
        exp_t        e;
        int          size;
        int          off;
        logic [63:0] slot;
        logic        err;
        e    = '{default: 0};
        size = (st == 3'd1) ? 1 : (st == 3'd2) ? 2 : (st == 3'd3) ? 4 : (st == 3'd4) ? 8 : 0;
        off  = int'(addr % 64'd8);
        slot = (addr - BASE) / 64'd4096;
        err  = (addr < BASE) || (slot >= 64'd4) || (st > 3'd4) ||
               (size > 1 && (addr % 64'(size)) != 64'd0);
        if (err) begin
            e.berr = 1'b1;
            e.lat  = 1;
            return e;
        end
        e.req   = 4'(1 << int'(slot));
        e.paddr = 12'((addr % 64'd4096) / 64'd8 * 64'd8);
        e.we    = (st != 3'd0);
        e.strb  = e.we ? 8'(((1 << size) - 1) << off) : 8'h00;
        e.wdata = wdata << (8 * off);
        if (slat >= 1 && slat <= 255) begin
            e.lat    = slat + 1;
            e.reqcyc = slat;
            e.rdata  = e.we ? 64'd0 : sdata;
        end else begin
            e.lat    = 256;
            e.reqcyc = 255;
            e.berr   = 1'b1;
        end
        return e;
    endfunction

    function automatic int hint_of(input logic [3:0] r);
        for (int i = 0; i < 4; i++) if (r[i]) return i;
        return 0;
    endfunction

    function automatic vec_t mkv(input logic [63:0] addr, input logic [63:0] wdata, input logic [2:0] st,
                                 input int slat, input logic [63:0] sdata, input logic [63:0] rdata,
                                 input logic [63:0] ewdata, input logic [11:0] paddr, input logic [7:0] strb,
                                 input logic [3:0] req, input logic we, input logic berr,
                                 input int lat, input int reqcyc);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.st = st; v.slat = slat; v.sdata = sdata;
        v.e.rdata = rdata; v.e.wdata = ewdata; v.e.paddr = paddr; v.e.strb = strb;
        v.e.req = req; v.e.we = we; v.e.berr = berr; v.e.lat = lat; v.e.reqcyc = reqcyc;
        return v;
    endfunction

    function automatic vec_t mkerr(input logic [63:0] addr, input logic [63:0] wdata, input logic [2:0] st);
        return mkv(addr, wdata, st, 1, 64'h0, 64'h0, 64'h0, 12'h0, 8'h0, 4'h0, 1'b0, 1'b1, 1, 0);
    endfunction

    // Drives one request; the selected slave (whichever the DUT asks) raises
    // ready in its slat-th REQ cycle (slat=0: never). Unselected ready bits toggle randomly.
    task automatic run_txn(input logic [63:0] addr, input logic [63:0] wdata, input logic [2:0] st,
                           input int slat, input int hint, input logic [63:0] sdata, output res_t r);
        r = '{default: 0};
        r.lat = -1;
        bus.d_addr       = addr;
        bus.d_wdata      = wdata;
        bus.d_store_type = st;
        bus.d_valid      = 1'b1;
        for (int i = 0; i < 4; i++)
            bus.p_rdata[64*i +: 64] = (i == hint) ? sdata : {$urandom, $urandom};
        bus.p_ready = 4'($urandom);
        for (int c = 1; c <= 300; c++) begin
            @(posedge clock);
            #1;
            if (bus.p_req != 4'd0) begin
                r.reqcyc++;
                if (r.reqcyc == 1) begin
                    r.req   = bus.p_req;
                    r.paddr = bus.p_addr;
                    r.we    = bus.p_we;
                    r.strb  = bus.p_wstrb;
                    r.wdata = bus.p_wdata;
                end else if (bus.p_req !== r.req) begin
                    r.req_bad++;
                end
            end
            if (bus.bus_error && !bus.d_ready) r.stray++;
            if (bus.d_ready) begin
                r.lat      = c;
                r.rdata    = bus.d_rdata;
                r.berr     = bus.bus_error;
                r.err_addr = bus.err_addr;
                r.done_cyc = cyc;
                break;
            end
            for (int i = 0; i < 4; i++)
                bus.p_ready[i] = bus.p_req[i] ? (slat != 0 && r.reqcyc == slat) : 1'($urandom);
        end
        bus.d_valid = 1'b0;
        bus.p_ready = '0;
        @(posedge clock);
        #1;
        r.ready_after = bus.d_ready;
        if (bus.bus_error) r.stray++;
    endtask

    task automatic check_txn(input string nm, input logic [63:0] addr, input exp_t e, input res_t r);
        if (e.berr) last_err = addr;
        check({nm, ".lat"},       64'(r.lat),         64'(e.lat));
        check({nm, ".reqcyc"},    64'(r.reqcyc),      64'(e.reqcyc));
        check({nm, ".bus_error"}, 64'(r.berr),        64'(e.berr));
        check({nm, ".d_rdata"},   r.rdata,            e.rdata);
        check({nm, ".err_addr"},  r.err_addr,         last_err);
        check({nm, ".stray_err"}, 64'(r.stray),       64'd0);
        check({nm, ".one_pulse"}, 64'(r.ready_after), 64'd0);
        if (e.reqcyc > 0) begin
            check({nm, ".p_req"},     64'(r.req),     64'(e.req));
            check({nm, ".req_hold"},  64'(r.req_bad), 64'd0);
            check({nm, ".p_addr"},    64'(r.paddr),   64'(e.paddr));
            check({nm, ".p_we"},      64'(r.we),      64'(e.we));
            check({nm, ".p_wstrb"},   64'(r.strb),    64'(e.strb));
            if (e.we) check({nm, ".p_wdata"}, r.wdata, e.wdata);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[11];
        res_t        r, r2;
        exp_t        e;
        logic [63:0] a, wd, sd;
        logic [2:0]  st;
        int          sl, seen;

        tbl[0]  = mkv(64'h2000_1010, 64'h0, 3'd0, 3, 64'h1122334455667788, 64'h1122334455667788,
                      64'h0, 12'h010, 8'h00, 4'b0010, 1'b0, 1'b0, 4, 3);
        tbl[1]  = mkv(64'h2000_0005, 64'hAB, 3'd1, 1, 64'h5555, 64'h0,
                      64'h0000_AB00_0000_0000, 12'h000, 8'h20, 4'b0001, 1'b1, 1'b0, 2, 1);
        tbl[2]  = mkerr(64'h2000_2002, 64'h1234_5678, 3'd3);
        tbl[3]  = mkerr(64'h2000_4000, 64'h0, 3'd0);
        tbl[4]  = mkerr(64'h1FFF_FFF8, 64'h0, 3'd0);
        tbl[5]  = mkv(64'h2000_2008, 64'h0, 3'd0, 0, 64'h99, 64'h0,
                      64'h0, 12'h008, 8'h00, 4'b0100, 1'b0, 1'b1, 256, 255);
        tbl[6]  = mkv(64'h2000_3FFE, 64'h1234, 3'd2, 2, 64'h77, 64'h0,
                      64'h1234_0000_0000_0000, 12'hFF8, 8'hC0, 4'b1000, 1'b1, 1'b0, 3, 2);
        tbl[7]  = mkv(64'h2000_1000, 64'hDEAD_BEEF_CAFE_F00D, 3'd4, 1, 64'h66, 64'h0,
                      64'hDEAD_BEEF_CAFE_F00D, 12'h000, 8'hFF, 4'b0010, 1'b1, 1'b0, 2, 1);
        tbl[8]  = mkerr(64'h2000_0000, 64'h0, 3'd5);
        tbl[9]  = mkv(64'h2000_0100, 64'h0, 3'd0, 255, 64'h0F0E_0D0C_0B0A_0908, 64'h0F0E_0D0C_0B0A_0908,
                      64'h0, 12'h100, 8'h00, 4'b0001, 1'b0, 1'b0, 256, 255);
        tbl[10] = mkv(64'h2000_300C, 64'h8765_4321, 3'd3, 5, 64'h44, 64'h0,
                      64'h8765_4321_0000_0000, 12'h008, 8'hF0, 4'b1000, 1'b1, 1'b0, 6, 5);

        bus.d_addr = '0; bus.d_wdata = '0; bus.d_store_type = '0; bus.d_valid = 1'b0;
        bus.p_rdata = '0; bus.p_ready = '0;

        #22;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        foreach (tbl[k]) begin
            run_txn(tbl[k].addr, tbl[k].wdata, tbl[k].st, tbl[k].slat,
                    hint_of(tbl[k].e.req), tbl[k].sdata, r);
            check_txn($sformatf("vec%0d", k), tbl[k].addr, tbl[k].e, r);
        end

        // Back-to-back with first-cycle ready: d_ready pulses 3 cycles apart
        e = model(64'h2000_0008, 64'h0, 3'd0, 1, 64'hA5A5_0000_1111_2222);
        run_txn(64'h2000_0008, 64'h0, 3'd0, 1, 0, 64'hA5A5_0000_1111_2222, r);
        check_txn("b2b_a", 64'h2000_0008, e, r);
        e = model(64'h2000_3010, 64'h0, 3'd0, 1, 64'h3333_4444_5555_6666);
        run_txn(64'h2000_3010, 64'h0, 3'd0, 1, 3, 64'h3333_4444_5555_6666, r2);
        check_txn("b2b_b", 64'h2000_3010, e, r2);
        check("b2b_spacing", 64'(r2.done_cyc - r.done_cyc), 64'd3);

        // Reset while the request is outstanding
        bus.d_addr = 64'h2000_1018; bus.d_store_type = 3'd0; bus.d_valid = 1'b1; bus.p_ready = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_mid.p_req_before", 64'(bus.p_req), 64'(4'b0010));
        #2 reset = 1'b1;
        #1;
        check_all_zero("rst_mid");
        last_err = '0;
        bus.d_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        seen = 0;
        repeat (4) begin
            @(posedge clock);
            #1;
            if (bus.d_ready) seen++;
        end
        check("rst_mid.no_ready", 64'(seen), 64'd0);
        e = model(64'h2000_2020, 64'h0, 3'd0, 2, 64'hCAFE_0000_BEEF_0001);
        run_txn(64'h2000_2020, 64'h0, 3'd0, 2, 2, 64'hCAFE_0000_BEEF_0001, r);
        check_txn("after_rst", 64'h2000_2020, e, r);

        // Randomized requests against the reference model
        for (int n = 0; n < 120; n++) begin
            int rg;
            rg = $urandom_range(0, 9);
            if (rg < 7) begin
                a = BASE + 64'($urandom_range(0, 3)) * 64'd4096 + 64'($urandom_range(0, 4095));
                if ($urandom_range(0, 2) != 0) a = a & ~64'd7;
            end else if (rg == 7) begin
                a = BASE + 64'($urandom_range(4, 5)) * 64'd4096 + 64'($urandom_range(0, 4095));
            end else if (rg == 8) begin
                a = BASE - 64'($urandom_range(1, 8192));
            end else begin
                a = {$urandom, $urandom};
            end
            st = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            sl = ($urandom_range(0, 29) == 0) ? 0 : $urandom_range(1, 6);
            wd = {$urandom, $urandom};
            sd = {$urandom, $urandom};
            e  = model(a, wd, st, sl, sd);
            run_txn(a, wd, st, sl, hint_of(e.req), sd, r);
            check_txn($sformatf("rnd%0d", n), a, e, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
